// File: rtl/fab_clk_rst_pkg.sv
// Shared state encoding, default timing constants and counter sizing helper.
// Latency: none (definitions only).
// Backpressure: not applicable.
package fab_clk_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_LOCK_FILTER   = 8;
  localparam int unsigned DEF_TICK_DIV      = 50;

  // Counter width for a count range of n values, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fab_clk_rst_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_i domain.
// Latency: 2 clk_i cycles from input capture to q_o.
// Backpressure: none; free-running level path.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw level through two flops; both clear asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fab_clk_rst_ctrl.sv
// Fabric reset sequencer: waits for init and a stable PLL lock, then releases reset and ticks.
// Latency: 2-cycle input sync, 1 cycle WAIT_LOCK, STABLE_CYCLES in STABILIZE before release.
// Backpressure: none; lock loss is filtered over LOCK_FILTER samples before reset re-asserts.
module fab_clk_rst_ctrl
  import fab_clk_rst_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LOCK_FILTER   = DEF_LOCK_FILTER,
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic PLL_LOCK,
  input  logic INIT_DONE,
  input  logic CLR_LOST,
  output logic FAB_RESET_N,
  output logic READY,
  output logic LOCK_LOST,
  output logic TICK
);

  localparam int unsigned SW = cnt_w(STABLE_CYCLES);
  localparam int unsigned FW = cnt_w(LOCK_FILTER);
  localparam int unsigned TW = cnt_w(TICK_DIV);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic lock_s;
  logic init_s;

  state_e        state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          fab_rst_n_q;
  logic          lost_q, lost_d;
  logic          lost_set;

  sync_2ff u_sync_lock (
    .clk_i  (CLK),
    .rst_ni (RESETN),
    .d_i    (PLL_LOCK),
    .q_o    (lock_s)
  );

  sync_2ff u_sync_init (
    .clk_i  (CLK),
    .rst_ni (RESETN),
    .d_i    (INIT_DONE),
    .q_o    (init_s)
  );

  // Next state, stability/filter counters and the lock-loss set event.
  always_comb begin
    state_d  = state_q;
    stab_d   = '0;
    filt_d   = '0;
    lost_set = 1'b0;
    unique case (state_q)
      ST_WAIT_INIT: begin
        if (init_s) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) state_d = ST_STABILIZE;
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_RUN;
          stab_d  = stab_q;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (lock_s) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d  = ST_LOST;
          filt_d   = filt_q;
          lost_set = 1'b1;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      ST_LOST: begin
        state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_WAIT_INIT;
      end
    endcase
    // Losing init overrides every other transition, including a pending lock loss.
    if (!init_s) begin
      state_d  = ST_WAIT_INIT;
      stab_d   = '0;
      filt_d   = '0;
      lost_set = 1'b0;
    end
  end

  // Tick divider runs only while staying in RUN; it sits at zero otherwise.
  always_comb begin
    tick_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    end
  end

  // Sticky lock-loss flag; a new loss beats a simultaneous clear.
  always_comb begin
    lost_d = lost_q;
    if (lost_set)      lost_d = 1'b1;
    else if (CLR_LOST) lost_d = 1'b0;
  end

  // State, counters and registered outputs; all clear asynchronously on RESETN.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= ST_WAIT_INIT;
      stab_q      <= '0;
      filt_q      <= '0;
      tick_q      <= '0;
      fab_rst_n_q <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_q      <= stab_d;
      filt_q      <= filt_d;
      tick_q      <= tick_d;
      fab_rst_n_q <= (state_d == ST_RUN);
      lost_q      <= lost_d;
    end
  end

  assign FAB_RESET_N = fab_rst_n_q;
  assign READY       = (state_q == ST_RUN);
  assign LOCK_LOST   = lost_q;
  assign TICK        = (state_q == ST_RUN) && (tick_q == TICK_LAST);

endmodule

// File: tb/tb_fab_clk_rst_ctrl.sv
// Randomized scoreboard bench for fab_clk_rst_ctrl with an event-time reference model.
// Latency: expected event cycles derived from lock/init edges and the timing rules.
// Backpressure: not applicable.
module tb_fab_clk_rst_ctrl;

  localparam int STABLE = 1024;
  localparam int LF     = 8;
  localparam int TD     = 50;

  logic CLK;
  logic RESETN;
  logic PLL_LOCK;
  logic INIT_DONE;
  logic CLR_LOST;
  logic FAB_RESET_N;
  logic READY;
  logic LOCK_LOST;
  logic TICK;

  fab_clk_rst_ctrl #(
    .STABLE_CYCLES (STABLE),
    .LOCK_FILTER   (LF),
    .TICK_DIV      (TD)
  ) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .PLL_LOCK    (PLL_LOCK),
    .INIT_DONE   (INIT_DONE),
    .CLR_LOST    (CLR_LOST),
    .FAB_RESET_N (FAB_RESET_N),
    .READY       (READY),
    .LOCK_LOST   (LOCK_LOST),
    .TICK        (TICK)
  );

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  ev_t q_fab[$];
  ev_t q_lost[$];
  int  q_tick[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edge counter: cyc equals the number of rising edges seen so far.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic push_fab(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q_fab.push_back(e);
  endtask

  task automatic push_lost(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q_lost.push_back(e);
  endtask

  // One tick per TD cycles of residence in RUN, first one TD-1 cycles after entry.
  task automatic plan_ticks(input int r, input int f);
    for (int t = r + TD - 1; t < f; t += TD) q_tick.push_back(t);
  endtask

  // Monitor: every observed output change (or tick) is matched against the queues.
  logic prev_fab  = 1'b0;
  logic prev_lost = 1'b0;
  ev_t  mev;
  int   mt;
  always @(negedge CLK) begin
    if (FAB_RESET_N !== prev_fab) begin
      if (q_fab.size() == 0) begin
        chk("fab_unexpected_event", {31'd0, FAB_RESET_N}, {31'd0, prev_fab});
      end else begin
        mev = q_fab.pop_front();
        chk("fab_cycle", cyc, mev.cyc);
        chk("fab_value", {31'd0, FAB_RESET_N}, {31'd0, mev.val});
        chk("ready_value", {31'd0, READY}, {31'd0, mev.val});
      end
      prev_fab = FAB_RESET_N;
    end
    if (TICK === 1'b1) begin
      if (q_tick.size() == 0) begin
        chk("tick_unexpected_at_cycle", cyc, 0);
      end else begin
        mt = q_tick.pop_front();
        chk("tick_cycle", cyc, mt);
      end
    end
    if (LOCK_LOST !== prev_lost) begin
      if (q_lost.size() == 0) begin
        chk("lost_unexpected_event", {31'd0, LOCK_LOST}, {31'd0, prev_lost});
      end else begin
        mev = q_lost.pop_front();
        chk("lost_cycle", cyc, mev.cyc);
        chk("lost_value", {31'd0, LOCK_LOST}, {31'd0, mev.val});
      end
      prev_lost = LOCK_LOST;
    end
  end

  // Watchdog bounds the whole run.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  int c1, r, g, dl, f, n, ret, s, cl, r3, di, e, r4, ra;

  initial begin
    RESETN    = 1'b0;
    INIT_DONE = 1'b0;
    PLL_LOCK  = 1'b0;
    CLR_LOST  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_fab_reset_n", {31'd0, FAB_RESET_N}, 0);
    chk("reset_ready",       {31'd0, READY}, 0);
    chk("reset_lock_lost",   {31'd0, LOCK_LOST}, 0);
    chk("reset_tick",        {31'd0, TICK}, 0);

    // Phase 1: init first, then lock; 7-cycle glitch ignored, 8-cycle loss trips.
    RESETN    = 1'b1;
    INIT_DONE = 1'b1;
    wait_until(cyc + 5);
    c1 = cyc;
    PLL_LOCK = 1'b1;
    r  = c1 + 2 + 1 + STABLE;
    g  = r + 100 + int'($urandom_range(0, 40));
    dl = r + 250 + int'($urandom_range(0, 49));
    f  = dl + 2 + LF;
    push_fab(r, 1'b1);
    plan_ticks(r, f);
    push_fab(f, 1'b0);
    push_lost(f, 1'b1);
    wait_until(g);
    PLL_LOCK = 1'b0;
    wait_until(g + LF - 1);
    PLL_LOCK = 1'b1;
    wait_until(dl);
    PLL_LOCK = 1'b0;
    wait_until(dl + LF);
    PLL_LOCK = 1'b1;
    ret = dl + LF;

    // Phase 2: re-stabilize after LOST (LOST and WAIT_LOCK take one cycle each),
    // one-cycle dropout at count 500 restarts the count.
    s  = imax(ret + 3, f + 2);
    g  = s + 500;
    r  = g + 1 + 3 + STABLE;
    n  = LF + 2 + int'($urandom_range(0, 3));
    dl = r + 60 + int'($urandom_range(0, 49));
    f  = dl + 2 + LF;
    push_fab(r, 1'b1);
    plan_ticks(r, f);
    push_fab(f, 1'b0);
    wait_until(g);
    PLL_LOCK = 1'b0;
    wait_until(g + 1);
    PLL_LOCK = 1'b1;
    // Coincident clear and new loss: flag must stay set (no lost event queued).
    wait_until(dl);
    PLL_LOCK = 1'b0;
    wait_until(f - 1);
    CLR_LOST = 1'b1;
    wait_until(f);
    CLR_LOST = 1'b0;
    chk("lost_kept_on_coincident_clear", {31'd0, LOCK_LOST}, 1);
    wait_until(dl + n);
    PLL_LOCK = 1'b1;
    ret = dl + n;

    // Phase 3: clear alone while stabilizing, then INIT_DONE drop in RUN.
    s  = imax(ret + 3, f + 2);
    r3 = s + STABLE;
    cl = f + 20 + int'($urandom_range(0, 30));
    di = r3 + int'($urandom_range(10, 150));
    push_lost(cl + 1, 1'b0);
    push_fab(r3, 1'b1);
    plan_ticks(r3, di + 3);
    push_fab(di + 3, 1'b0);
    wait_until(cl);
    CLR_LOST = 1'b1;
    wait_until(cl + 1);
    CLR_LOST = 1'b0;
    wait_until(di);
    INIT_DONE = 1'b0;
    e = di + 5;
    wait_until(e);
    INIT_DONE = 1'b1;

    // Phase 4: lock held, init back -> WAIT_INIT, WAIT_LOCK, STABILIZE; then async reset in RUN.
    r4 = e + 4 + STABLE;
    ra = r4 + int'($urandom_range(20, 120));
    push_fab(r4, 1'b1);
    plan_ticks(r4, ra + 1);
    push_fab(ra + 1, 1'b0);
    wait_until(ra);
    #2;
    RESETN = 1'b0;
    #1;
    chk("async_fab_reset_n", {31'd0, FAB_RESET_N}, 0);
    chk("async_ready",       {31'd0, READY}, 0);
    chk("async_lock_lost",   {31'd0, LOCK_LOST}, 0);
    chk("async_tick",        {31'd0, TICK}, 0);
    repeat (4) @(negedge CLK);

    chk("fab_events_left",  q_fab.size(), 0);
    chk("tick_events_left", q_tick.size(), 0);
    chk("lost_events_left", q_lost.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
